// File: rtl/alu_cmd_issuer_if.sv
// Bundles the command handshake, the ALU issue/response pair and the tagged
// result of alu_cmd_issuer; slave is the issuer side, master its environment.
interface alu_cmd_issuer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FUN_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [FUN_WIDTH-1:0]  cmd_fun;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;

    logic [FUN_WIDTH-1:0]  alu_fun;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic                  alu_en;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  alu_valid;

    logic [DATA_WIDTH-1:0] res;
    logic [FUN_WIDTH-1:0]  res_fun;
    logic                  res_valid;
    logic                  err;

    modport slave (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, alu_valid,
        output cmd_ready, alu_fun, alu_a, alu_b, alu_en,
               res, res_fun, res_valid, err
    );

    modport master (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, alu_valid,
        input  cmd_ready, alu_fun, alu_a, alu_b, alu_en,
               res, res_fun, res_valid, err
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command FIFO in front of the 16-bit ALU: issues one command at a time, waits
// for the ALU result (or a watchdog timeout) and returns it tagged with its function.
module alu_cmd_issuer #(
    parameter int DATA_WIDTH = 16,
    parameter int FUN_WIDTH  = 4,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_cmd_issuer_if.slave        bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef struct packed {
        logic [FUN_WIDTH-1:0]  fun;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } cmd_t;

    typedef enum logic {IDLE, WAIT} state_t;

    cmd_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   wdog;
    state_t          state;
    state_t          state_d;
    logic            push;
    logic            pop;
    logic            capture;
    logic            timeout;

    assign bus.cmd_ready = (count != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign busy          = (state != IDLE) || (count != '0);

    // NOTE: every output of an always_comb gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A result in the last watchdog cycle beats the timeout.
                if (bus.alu_valid) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (wdog == TW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count and the
    // pointers, so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{fun: bus.cmd_fun, a: bus.cmd_a, b: bus.cmd_b};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            wdog          <= '0;
            bus.alu_fun   <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_en    <= 1'b0;
            bus.res       <= '0;
            bus.res_fun   <= '0;
            bus.res_valid <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            count         <= count + CW'(push) - CW'(pop);
            bus.alu_en    <= pop;
            bus.res_valid <= capture;
            bus.err       <= timeout;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                bus.alu_fun <= mem[rd_ptr].fun;
                bus.alu_a   <= mem[rd_ptr].a;
                bus.alu_b   <= mem[rd_ptr].b;
                rd_ptr      <= rd_ptr + PW'(1);
                wdog        <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog + TW'(1);
            end
            if (capture) begin
                bus.res     <= bus.alu_out;
                bus.res_fun <= bus.alu_fun;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed timing scenarios plus random
// traffic, scored against a queue-based transaction model and a behavioural ALU.
module tb_alu_cmd_issuer;
    localparam int DW      = 16;
    localparam int FW      = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [FW-1:0] fun;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [2:0] count;

    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.DATA_WIDTH(DW), .FUN_WIDTH(FW)) ifc ();

    alu_cmd_issuer #(
        .DATA_WIDTH(DW), .FUN_WIDTH(FW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(ifc), .busy(busy), .count(count)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // Transaction model: accepted-but-not-issued commands and the one in flight.
    cmd_t        q[$];
    bit          inflight = 1'b0;
    cmd_t        inf;
    int          cyc = 0;
    int          en_cyc[$];
    int          err_cyc[$];
    int          res_cyc[$];
    logic [FW-1:0] res_fun_log[$];

    // Behavioural ALU: mode 0 = driven by hand, 1 = responds after a latency, 2 = never.
    int   alu_mode = 0;
    int   alu_lat  = 1;
    bit   rand_lat = 1'b0;
    int   alu_cd   = -1;
    cmd_t alu_pend;

    function automatic logic [DW-1:0] alu_ref(cmd_t c);
        return (c.a + c.b) ^ {4{c.fun}};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        en_cyc.delete();
        err_cyc.delete();
        res_cyc.delete();
        res_fun_log.delete();
    endtask

    task automatic monitor();
        cmd_t exp;
        if (ifc.alu_en) begin
            en_cyc.push_back(cyc);
            if (q.size() == 0) begin
                check("issue_while_empty", ifc.alu_en, 1'b0);
            end else begin
                exp = q.pop_front();
                check("issue_cmd", {ifc.alu_fun, ifc.alu_a, ifc.alu_b}, exp);
                inflight = 1'b1;
                inf      = exp;
            end
        end
        if (ifc.res_valid) begin
            res_cyc.push_back(cyc);
            res_fun_log.push_back(ifc.res_fun);
            check("res_inflight", inflight, 1'b1);
            check("res_value", ifc.res, alu_ref(inf));
            check("res_fun", ifc.res_fun, inf.fun);
            inflight = 1'b0;
        end
        if (ifc.err) begin
            err_cyc.push_back(cyc);
            check("err_inflight", inflight, 1'b1);
            inflight = 1'b0;
        end
        check("count", count, q.size());
        check("cmd_ready", ifc.cmd_ready, q.size() != DEPTH);
        check("busy", busy, inflight || (q.size() != 0));
    endtask

    task automatic alu_step();
        if (alu_mode != 0) ifc.alu_valid = 1'b0;
        if (alu_cd > 0) alu_cd--;
        if (alu_mode == 1 && ifc.alu_en) begin
            alu_pend = {ifc.alu_fun, ifc.alu_a, ifc.alu_b};
            alu_cd   = rand_lat ? int'($urandom_range(0, 4)) : alu_lat;
        end
        if (alu_cd == 0) begin
            ifc.alu_valid = 1'b1;
            ifc.alu_out   = alu_ref(alu_pend);
            alu_cd        = -1;
        end
    endtask

    // One clock: record any accepted push at the edge, then score on the falling edge.
    task automatic tick();
        bit   acc;
        cmd_t c;
        acc = rst && ifc.cmd_valid && ifc.cmd_ready;
        c   = {ifc.cmd_fun, ifc.cmd_a, ifc.cmd_b};
        @(posedge clk);
        if (acc) q.push_back(c);
        @(negedge clk);
        cyc++;
        monitor();
        alu_step();
    endtask

    // Holds the command until accepted; leaves cmd_valid high for back-to-back use.
    task automatic push_cmd(logic [FW-1:0] fun, logic [DW-1:0] a, logic [DW-1:0] b);
        bit acc;
        int n;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_fun   = fun;
        ifc.cmd_a     = a;
        ifc.cmd_b     = b;
        n = 0;
        do begin
            acc = ifc.cmd_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) check("push_accepted", acc, 1'b1);
    endtask

    task automatic drain(int limit);
        int n;
        n = 0;
        while ((q.size() != 0 || inflight) && n < limit) begin
            tick();
            n++;
        end
        check("drain_done", busy, 1'b0);
    endtask

    initial begin
        int   k;
        int   c1;
        int   acc6;
        int   n;
        logic [FW-1:0] funs [4];

        funs[0] = 4'h0; funs[1] = 4'h5; funs[2] = 4'hA; funs[3] = 4'hF;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_fun   = '0;
        ifc.cmd_a     = '0;
        ifc.cmd_b     = '0;
        ifc.alu_valid = 1'b0;
        ifc.alu_out   = '0;

        // Reset values
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_alu_fun", ifc.alu_fun, 4'h0);
        check("rst_alu_a", ifc.alu_a, 16'h0);
        check("rst_alu_b", ifc.alu_b, 16'h0);
        check("rst_res", ifc.res, 16'h0);
        check("rst_res_fun", ifc.res_fun, 4'h0);
        check("rst_alu_en", ifc.alu_en, 1'b0);
        check("rst_res_valid", ifc.res_valid, 1'b0);
        check("rst_err", ifc.err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_cmd_ready", ifc.cmd_ready, 1'b1);
        rst = 1'b1;
        tick();

        // Single op through a 1-cycle ALU
        alu_mode = 1; alu_lat = 1; rand_lat = 1'b0;
        clear_logs();
        push_cmd(4'h0, 16'h0005, 16'h0003);
        ifc.cmd_valid = 1'b0;
        k = cyc;
        repeat (5) tick();
        check("single_en_count", en_cyc.size(), 1);
        check("single_en_time", en_cyc.size() > 0 ? en_cyc[0] - k : -1, 1);
        check("single_res_count", res_cyc.size(), 1);
        check("single_res_time", res_cyc.size() > 0 ? res_cyc[0] - k : -1, 3);
        check("single_res", ifc.res, 16'h0008);
        check("single_res_fun", ifc.res_fun, 4'h0);

        // Fill and backpressure with a silent ALU; the head then times out
        alu_mode = 2;
        clear_logs();
        c1 = 0;
        acc6 = 0;
        for (int i = 0; i < 6; i++) begin
            push_cmd(FW'(i), 16'h0100 + DW'(i), 16'h0200 + DW'(i));
            if (i == 0) c1 = cyc;
            if (i == 4) begin
                check("fill_count", count, 3'd4);
                check("fill_ready", ifc.cmd_ready, 1'b0);
            end
            if (i == 5) acc6 = cyc;
        end
        ifc.cmd_valid = 1'b0;
        check("fill_first_issue", en_cyc.size() > 0 ? en_cyc[0] - c1 : -1, 1);
        check("to_err_count", err_cyc.size(), 1);
        if (err_cyc.size() >= 1 && en_cyc.size() >= 2) begin
            check("to_err_time", err_cyc[0] - en_cyc[0], TIMEOUT);
            check("to_next_issue", en_cyc[1] - err_cyc[0], 1);
            check("to_stall_release", acc6 - err_cyc[0], 2);
        end
        check("to_res_held", ifc.res, 16'h0008);
        check("to_no_res", res_cyc.size(), 0);
        repeat (3) tick();

        // Reset while a command is in flight and the FIFO is full
        #2 rst = 1'b0;
        #1;
        q.delete();
        inflight = 1'b0;
        alu_cd   = -1;
        check("mid_rst_count", count, 3'd0);
        check("mid_rst_ready", ifc.cmd_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_res", ifc.res, 16'h0);
        check("mid_rst_alu_a", ifc.alu_a, 16'h0);
        check("mid_rst_alu_fun", ifc.alu_fun, 4'h0);
        tick();
        rst = 1'b1;
        alu_mode = 0;
        clear_logs();
        ifc.alu_valid = 1'b1;
        ifc.alu_out   = 16'hBEEF;
        tick();
        ifc.alu_valid = 1'b0;
        tick();
        check("stray_no_res", res_cyc.size(), 0);
        check("stray_res", ifc.res, 16'h0);

        // Result arriving in the last watchdog cycle wins over the timeout
        alu_mode = 1; alu_lat = TIMEOUT - 1;
        clear_logs();
        push_cmd(4'h9, 16'h1234, 16'h4321);
        ifc.cmd_valid = 1'b0;
        n = 0;
        while (res_cyc.size() == 0 && err_cyc.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        check("race_no_err", err_cyc.size(), 0);
        check("race_res_count", res_cyc.size(), 1);
        if (res_cyc.size() > 0 && en_cyc.size() > 0)
            check("race_res_time", res_cyc[0] - en_cyc[0], TIMEOUT);

        // Ordering across FIFO wrap
        alu_lat = 1;
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                push_cmd(funs[i], 16'h1000 * DW'(i + 1) + DW'(r), 16'h0011 * DW'(i + 3 * r));
        ifc.cmd_valid = 1'b0;
        drain(100);
        check("order_len", res_fun_log.size(), 8);
        for (int i = 0; i < 8 && i < res_fun_log.size(); i++)
            check($sformatf("order_fun%0d", i), res_fun_log[i], funs[i % 4]);

        // Random traffic with random ALU latency
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ifc.cmd_valid = 1'($urandom_range(0, 1));
            ifc.cmd_fun   = FW'($urandom);
            ifc.cmd_a     = DW'($urandom);
            ifc.cmd_b     = DW'($urandom);
            tick();
        end
        ifc.cmd_valid = 1'b0;
        drain(200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
